// File: rtl/flash_rom_bridge.sv
// 6809 ROM window served from SPI flash: READ (03h) + 24-bit addr + dummy.
// Define FLASH_ROM_CACHE_EN for a one-entry read cache.
module flash_rom_bridge #(
  parameter logic [15:0] ROM_BASE       = 16'hC000,
  parameter logic [23:0] FLASH_BASE     = 24'h000000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_RW,
  input  logic        i_E,
  input  logic        i_Q,
  output logic [7:0]  o_DATA,
  output logic        o_DATA_OE,
  output logic        o_MRDY,
  output logic        o_TX_VALID,
  output logic [7:0]  o_TX_DATA,
  input  logic        i_TX_READY,
  input  logic        i_RX_VALID,
  input  logic [7:0]  i_RX_DATA,
  output logic        o_CS_HOLD,
  output logic        o_ERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADR2, S_ADR1,
    S_ADR0, S_DUMMY, S_WAIT, S_DRIVE
  } state_t;

  state_t state_q, state_d;

  logic        e_s1_q, e_s2_q, e_prev_q;
  logic        q_s1_q, q_s2_q, q_prev_q;
  logic        rw_s1_q, rw_s2_q;
  logic [15:0] addr_s1_q, addr_s2_q;

  logic          mrdy_q, mrdy_d;
  logic          oe_q, oe_d;
  logic [7:0]    data_q, data_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          cs_q, cs_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   fa_q, fa_d;

  logic        q_rise, e_fall, req, hs, busy, tmo, rx_done;
  logic        hit;
  logic [7:0]  hit_data;
  logic [23:0] fa_calc;

  assign q_rise  = q_s2_q & ~q_prev_q;
  assign e_fall  = e_prev_q & ~e_s2_q;
  assign req     = q_rise & rw_s2_q & (addr_s2_q >= ROM_BASE);
  assign hs      = txv_q & i_TX_READY;
  assign busy    = (state_q != S_IDLE) && (state_q != S_DRIVE);
  assign tmo     = (cnt_q == TO_LAST);
  assign rx_done = (state_q == S_WAIT) && i_RX_VALID;
  assign fa_calc = FLASH_BASE + (24'(addr_s2_q) - 24'(ROM_BASE));

`ifdef FLASH_ROM_CACHE_EN
  logic        c_vld_q, c_vld_d;
  logic [15:0] c_tag_q, c_tag_d;
  logic [7:0]  c_dat_q, c_dat_d;
  logic [15:0] req_addr_q, req_addr_d;

  assign hit      = c_vld_q && (c_tag_q == addr_s2_q);
  assign hit_data = c_dat_q;

  always_comb begin
    c_vld_d    = c_vld_q;
    c_tag_d    = c_tag_q;
    c_dat_d    = c_dat_q;
    req_addr_d = req_addr_q;
    if (state_q == S_IDLE && req) req_addr_d = addr_s2_q;
    if (rx_done) begin
      c_vld_d = 1'b1;
      c_tag_d = req_addr_q;
      c_dat_d = i_RX_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld_q    <= 1'b0;
      c_tag_q    <= '0;
      c_dat_q    <= '0;
      req_addr_q <= '0;
    end else begin
      c_vld_q    <= c_vld_d;
      c_tag_q    <= c_tag_d;
      c_dat_q    <= c_dat_d;
      req_addr_q <= req_addr_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 8'h00;
`endif

  always_comb begin
    state_d = state_q;
    mrdy_d  = mrdy_q;
    data_d  = data_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    cs_d    = cs_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    fa_d    = fa_q;
    if (busy) cnt_d = cnt_q + CW'(1);
    // A byte arriving on the last allowed cycle still wins over the timeout
    if (busy && tmo && !rx_done) begin
      state_d = S_DRIVE;
      data_d  = 8'hFF;
      err_d   = 1'b1;
      mrdy_d  = 1'b1;
      txv_d   = 1'b0;
      txd_d   = 8'h00;
      cs_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req && hit) begin
            state_d = S_DRIVE;
            data_d  = hit_data;
          end else if (req) begin
            state_d = S_CMD;
            mrdy_d  = 1'b0;
            txv_d   = 1'b1;
            txd_d   = 8'h03;
            cs_d    = 1'b1;
            cnt_d   = '0;
            fa_d    = fa_calc;
          end
        end
        S_CMD: if (hs) begin
          state_d = S_ADR2;
          txd_d   = fa_q[23:16];
        end
        S_ADR2: if (hs) begin
          state_d = S_ADR1;
          txd_d   = fa_q[15:8];
        end
        S_ADR1: if (hs) begin
          state_d = S_ADR0;
          txd_d   = fa_q[7:0];
        end
        S_ADR0: if (hs) begin
          state_d = S_DUMMY;
          txd_d   = 8'h00;
        end
        S_DUMMY: if (hs) begin
          state_d = S_WAIT;
          txv_d   = 1'b0;
        end
        S_WAIT: if (i_RX_VALID) begin
          state_d = S_DRIVE;
          data_d  = i_RX_DATA;
          mrdy_d  = 1'b1;
          cs_d    = 1'b0;
        end
        S_DRIVE: if (e_fall) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    oe_d = (state_d == S_DRIVE) && e_s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_s1_q    <= 1'b0;
      e_s2_q    <= 1'b0;
      e_prev_q  <= 1'b0;
      q_s1_q    <= 1'b0;
      q_s2_q    <= 1'b0;
      q_prev_q  <= 1'b0;
      rw_s1_q   <= 1'b0;
      rw_s2_q   <= 1'b0;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      state_q   <= S_IDLE;
      mrdy_q    <= 1'b1;
      oe_q      <= 1'b0;
      data_q    <= '0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
      cs_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      fa_q      <= '0;
    end else begin
      e_s1_q    <= i_E;
      e_s2_q    <= e_s1_q;
      e_prev_q  <= e_s2_q;
      q_s1_q    <= i_Q;
      q_s2_q    <= q_s1_q;
      q_prev_q  <= q_s2_q;
      rw_s1_q   <= i_RW;
      rw_s2_q   <= rw_s1_q;
      addr_s1_q <= i_ADDRESS_BUS;
      addr_s2_q <= addr_s1_q;
      state_q   <= state_d;
      mrdy_q    <= mrdy_d;
      oe_q      <= oe_d;
      data_q    <= data_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
      cs_q      <= cs_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      fa_q      <= fa_d;
    end
  end

  assign o_DATA     = data_q;
  assign o_DATA_OE  = oe_q;
  assign o_MRDY     = mrdy_q;
  assign o_TX_VALID = txv_q;
  assign o_TX_DATA  = txd_q;
  assign o_CS_HOLD  = cs_q;
  assign o_ERR      = err_q;

endmodule

// File: tb/tb_flash_rom_bridge.sv
// Directed bench for flash_rom_bridge: 6809 bus model plus SPI master model.
// Builds with or without FLASH_ROM_CACHE_EN.
module tb_flash_rom_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_ADDRESS_BUS;
  logic        i_RW, i_E, i_Q;
  logic [7:0]  o_DATA;
  logic        o_DATA_OE, o_MRDY, o_TX_VALID;
  logic [7:0]  o_TX_DATA;
  logic        i_TX_READY, i_RX_VALID;
  logic [7:0]  i_RX_DATA;
  logic        o_CS_HOLD, o_ERR;

  always #5 clk = ~clk;

  flash_rom_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .i_ADDRESS_BUS(i_ADDRESS_BUS), .i_RW(i_RW),
    .i_E(i_E), .i_Q(i_Q),
    .o_DATA(o_DATA), .o_DATA_OE(o_DATA_OE), .o_MRDY(o_MRDY),
    .o_TX_VALID(o_TX_VALID), .o_TX_DATA(o_TX_DATA),
    .i_TX_READY(i_TX_READY),
    .i_RX_VALID(i_RX_VALID), .i_RX_DATA(i_RX_DATA),
    .o_CS_HOLD(o_CS_HOLD), .o_ERR(o_ERR)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      passed++;
  endtask

  // SPI master model settings (written by the test, read by the model)
  int         stall_cfg = 0;
  logic       rx_en = 1'b1;
  logic [7:0] rx_byte = 8'h00;

  // Model-owned state
  logic [7:0] tx_log[$];
  int         unstable = 0;
  int         mrdy_low_cnt = 0;
  int         cs_cnt = 0;

  initial begin
    int seq, stall;
    logic hs_pend;
    logic [7:0] held, pend_byte;
    seq = 0; stall = 0; hs_pend = 1'b0; held = '0; pend_byte = '0;
    i_TX_READY = 1'b0; i_RX_VALID = 1'b0; i_RX_DATA = 8'h00;
    forever begin
      @(negedge clk);
      i_RX_VALID = 1'b0;
      if (!rst_n) begin
        hs_pend = 1'b0; seq = 0; stall = 0; i_TX_READY = 1'b0;
      end else begin
        if (hs_pend) begin
          tx_log.push_back(pend_byte);
          seq++;
          stall = 0;
          if (rx_en) begin
            i_RX_VALID = 1'b1;
            i_RX_DATA  = (seq == 5) ? rx_byte : 8'h11;
          end
          if (seq == 5) seq = 0;
        end
        hs_pend = 1'b0;
        i_TX_READY = 1'b0;
        if (o_TX_VALID) begin
          if (stall == 0) held = o_TX_DATA;
          else if (o_TX_DATA !== held) unstable++;
          if (stall < stall_cfg) stall++;
          else begin
            i_TX_READY = 1'b1;
            hs_pend = 1'b1;
            pend_byte = o_TX_DATA;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (o_MRDY === 1'b0) mrdy_low_cnt++;
    if (o_CS_HOLD === 1'b1) cs_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 6809 bus cycle: Q rises, then E; E is stretched while MRDY is low.
  task automatic bus_cycle(input logic [15:0] a, input logic rw,
                           output int base, output int ntx,
                           output logic [7:0] d, output logic oe,
                           output logic mlow, output logic cs_seen);
    int m0, c0, u0;
    m0 = mrdy_low_cnt; c0 = cs_cnt; u0 = unstable;
    base = tx_log.size();
    @(negedge clk);
    i_ADDRESS_BUS = a; i_RW = rw; i_Q = 1'b1;
    cycles(4);
    i_E = 1'b1;
    cycles(4);
    i_Q = 1'b0;
    for (int i = 0; i < 3000 && o_MRDY !== 1'b1; i++) @(negedge clk);
    chk("mrdy_release", {31'b0, o_MRDY}, 32'd1);
    cycles(4);
    d = o_DATA;
    oe = o_DATA_OE;
    i_E = 1'b0;
    cycles(5);
    chk("oe_drop", {31'b0, o_DATA_OE}, 32'd0);
    chk("tx_stable", unstable - u0, 0);
    ntx = tx_log.size() - base;
    mlow = (mrdy_low_cnt != m0);
    cs_seen = (cs_cnt != c0);
  endtask

  task automatic chk_seq(input string nm, input int base,
                         input logic [15:0] a);
    logic [23:0] fa;
    logic [7:0]  e [5];
    fa = 24'h000000 + (24'(a) - 24'hC000);
    e[0] = 8'h03; e[1] = fa[23:16]; e[2] = fa[15:8];
    e[3] = fa[7:0]; e[4] = 8'h00;
    for (int k = 0; k < 5; k++)
      chk($sformatf("%s_tx%0d", nm, k),
          {24'b0, (tx_log.size() > base + k) ? tx_log[base + k] : 8'hxx},
          {24'b0, e[k]});
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    int          stall;
    logic [7:0]  rx;
    int          ntx;
    logic [7:0]  data;
    logic        oe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int base, ntx;
    logic [7:0] d;
    logic oe, mlow, cs_seen;
    logic [7:0] exp_d2;
    int exp_n2;
    logic exp_ml2;

    vecs[0] = '{16'hFFFE, 1'b1, 0, 8'hA5, 5, 8'hA5, 1'b1};
    vecs[1] = '{16'h8000, 1'b1, 0, 8'h00, 0, 8'h00, 1'b0};
    vecs[2] = '{16'hC000, 1'b0, 0, 8'h00, 0, 8'h00, 1'b0};
    vecs[3] = '{16'hC123, 1'b1, 5, 8'h3C, 5, 8'h3C, 1'b1};
    vecs[4] = '{16'hBFFF, 1'b1, 0, 8'h00, 0, 8'h00, 1'b0};
    vecs[5] = '{16'hD000, 1'b1, 2, 8'h5A, 5, 8'h5A, 1'b1};
    vecs[6] = '{16'hC000, 1'b1, 0, 8'h81, 5, 8'h81, 1'b1};

    rst_n = 1'b0;
    i_ADDRESS_BUS = '0; i_RW = 1'b1; i_E = 1'b0; i_Q = 1'b0;
    cycles(3);
    chk("rst_mrdy", {31'b0, o_MRDY}, 32'd1);
    chk("rst_oe", {31'b0, o_DATA_OE}, 32'd0);
    chk("rst_data", {24'b0, o_DATA}, 32'h00);
    chk("rst_txv", {31'b0, o_TX_VALID}, 32'd0);
    chk("rst_cs", {31'b0, o_CS_HOLD}, 32'd0);
    chk("rst_err", {31'b0, o_ERR}, 32'd0);
    rst_n = 1'b1;
    cycles(3);

    foreach (vecs[i]) begin
      stall_cfg = vecs[i].stall;
      rx_byte   = vecs[i].rx;
      rx_en     = 1'b1;
      bus_cycle(vecs[i].addr, vecs[i].rw, base, ntx, d, oe, mlow, cs_seen);
      chk($sformatf("v%0d_ntx", i), ntx, vecs[i].ntx);
      chk($sformatf("v%0d_oe", i), {31'b0, oe}, {31'b0, vecs[i].oe});
      chk($sformatf("v%0d_mrdy_low", i), {31'b0, mlow},
          {31'b0, vecs[i].ntx != 0});
      chk($sformatf("v%0d_cs", i), {31'b0, cs_seen},
          {31'b0, vecs[i].ntx != 0});
      if (vecs[i].oe) begin
        chk($sformatf("v%0d_data", i), {24'b0, d}, {24'b0, vecs[i].data});
        chk_seq($sformatf("v%0d", i), base, vecs[i].addr);
      end
    end
    chk("err_clean", {31'b0, o_ERR}, 32'd0);

    // Timeout: SPI model never returns a byte
    stall_cfg = 0; rx_en = 1'b0;
    bus_cycle(16'hE000, 1'b1, base, ntx, d, oe, mlow, cs_seen);
    chk("to_data", {24'b0, d}, 32'hFF);
    chk("to_oe", {31'b0, oe}, 32'd1);
    chk("to_err", {31'b0, o_ERR}, 32'd1);
    chk("to_ntx", ntx, 5);
    rx_en = 1'b1; rx_byte = 8'h77;
    bus_cycle(16'hE001, 1'b1, base, ntx, d, oe, mlow, cs_seen);
    chk("after_to_data", {24'b0, d}, 32'h77);
    chk("after_to_err", {31'b0, o_ERR}, 32'd1);
    chk_seq("after_to", base, 16'hE001);

    // Reset while the bridge is stalled sending ADR1
    stall_cfg = 20;
    base = tx_log.size();
    @(negedge clk);
    i_ADDRESS_BUS = 16'hFFFE; i_RW = 1'b1; i_Q = 1'b1;
    for (int i = 0; i < 200 && tx_log.size() < base + 2; i++)
      @(negedge clk);
    chk("adr1_reached", tx_log.size() - base, 2);
    cycles(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mrdy", {31'b0, o_MRDY}, 32'd1);
    chk("mid_rst_txv", {31'b0, o_TX_VALID}, 32'd0);
    chk("mid_rst_txd", {24'b0, o_TX_DATA}, 32'h00);
    chk("mid_rst_cs", {31'b0, o_CS_HOLD}, 32'd0);
    chk("mid_rst_err", {31'b0, o_ERR}, 32'd0);
    chk("mid_rst_data", {24'b0, o_DATA}, 32'h00);
    chk("mid_rst_oe", {31'b0, o_DATA_OE}, 32'd0);
    i_Q = 1'b0; i_E = 1'b0; stall_cfg = 0;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    rx_byte = 8'h42;
    bus_cycle(16'hC000, 1'b1, base, ntx, d, oe, mlow, cs_seen);
    chk("post_rst_ntx", ntx, 5);
    chk("post_rst_data", {24'b0, d}, 32'h42);
    chk_seq("post_rst", base, 16'hC000);

    // Back-to-back reads of one address
    rx_byte = 8'h6B;
    bus_cycle(16'hC123, 1'b1, base, ntx, d, oe, mlow, cs_seen);
    chk("rep1_ntx", ntx, 5);
    chk("rep1_data", {24'b0, d}, 32'h6B);
`ifdef FLASH_ROM_CACHE_EN
    exp_n2 = 0; exp_d2 = 8'h6B; exp_ml2 = 1'b0;
`else
    exp_n2 = 5; exp_d2 = 8'h99; exp_ml2 = 1'b1;
`endif
    rx_byte = 8'h99;
    bus_cycle(16'hC123, 1'b1, base, ntx, d, oe, mlow, cs_seen);
    chk("rep2_ntx", ntx, exp_n2);
    chk("rep2_data", {24'b0, d}, {24'b0, exp_d2});
    chk("rep2_oe", {31'b0, oe}, 32'd1);
    chk("rep2_mrdy_low", {31'b0, mlow}, {31'b0, exp_ml2});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
